// File: rtl/param_bank_loader_if.sv
// Bus bundle for param_bank_loader: single-word write/read port plus the
// raster-order stream-load handshake and status flags.
interface param_bank_loader_if #(
    parameter int DATA_W = 16,
    parameter int ROWS   = 4,
    parameter int COLS   = 16
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic              write;
    logic [RW-1:0]     seli;
    logic [CW-1:0]     selj;
    logic [DATA_W-1:0] param_in;
    logic [DATA_W-1:0] param_out;
    logic              load_start;
    logic              load_valid;
    logic              load_ready;
    logic              load_abort;
    logic              load_done;
    logic              busy;

    modport master (
        output write, seli, selj, param_in, load_start, load_valid, load_abort,
        input  param_out, load_ready, load_done, busy
    );

    modport slave (
        input  write, seli, selj, param_in, load_start, load_valid, load_abort,
        output param_out, load_ready, load_done, busy
    );
endinterface

// File: rtl/param_bank_loader.sv
// ROWS x COLS parameter bank with single-word writes and a raster-order stream
// loader. Define PARAM_BANK_REG_READ_EN for a registered (1-cycle) read port.
module param_bank_loader #(
    parameter int DATA_W = 16,
    parameter int ROWS   = 4,
    parameter int COLS   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    param_bank_loader_if.slave bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW:0]   ROWS_L   = (RW+1)'(ROWS);
    localparam logic [CW:0]   COLS_L   = (CW+1)'(COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [DATA_W-1:0] bank_q [ROWS][COLS];

    logic              sel_ok_s;
    logic              wr_en_s;
    logic [RW-1:0]     wr_row_s;
    logic [CW-1:0]     wr_col_s;
    logic [DATA_W-1:0] rd_data_s;

    // Non-power-of-two geometries leave holes in the select space.
    assign sel_ok_s = ({1'b0, bus.seli} < ROWS_L) && ({1'b0, bus.selj} < COLS_L);

    assign bus.load_ready = (state_q == STREAM);
    assign bus.load_done  = (state_q == DONE);
    assign bus.busy       = (state_q != IDLE);

    // State, stream pointer and bank write-port selection.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        wr_en_s  = 1'b0;
        wr_row_s = row_q;
        wr_col_s = col_q;
        case (state_q)
            IDLE: begin
                if (bus.write && sel_ok_s) begin
                    wr_en_s  = 1'b1;
                    wr_row_s = bus.seli;
                    wr_col_s = bus.selj;
                end else begin
                    wr_en_s  = 1'b0;
                end
                if (bus.load_start) begin
                    state_d = STREAM;
                    row_d   = {RW{1'b0}};
                    col_d   = {CW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                // Abort wins over a coincident valid word.
                if (bus.load_abort) begin
                    state_d = IDLE;
                end else if (bus.load_valid) begin
                    wr_en_s = 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d = {CW{1'b0}};
                        if (row_q == ROW_LAST) begin
                            row_d   = {RW{1'b0}};
                            state_d = DONE;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end else begin
                    state_d = STREAM;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            row_q   <= {RW{1'b0}};
            col_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Bank storage; reset clears every word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    bank_q[r][c] <= {DATA_W{1'b0}};
                end
            end
        end else if (wr_en_s) begin
            bank_q[wr_row_s][wr_col_s] <= bus.param_in;
        end
    end

    // Read mux; holes in the address space read as zero.
    always_comb begin
        if (sel_ok_s) begin
            rd_data_s = bank_q[bus.seli][bus.selj];
        end else begin
            rd_data_s = {DATA_W{1'b0}};
        end
    end

`ifdef PARAM_BANK_REG_READ_EN
    logic [DATA_W-1:0] rd_q;

    // Registered read port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q <= {DATA_W{1'b0}};
        end else begin
            rd_q <= rd_data_s;
        end
    end

    assign bus.param_out = rd_q;
`else
    assign bus.param_out = rd_data_s;
`endif

endmodule

// File: tb/tb_param_bank_loader.sv
// Directed self-checking bench for param_bank_loader: a 4x16 instance for the
// main behaviour and a 3x5 instance for non-power-of-two geometry.
module tb_param_bank_loader;
`ifdef PARAM_BANK_REG_READ_EN
    localparam int RD_LAT = 1;
`else
    localparam int RD_LAT = 0;
`endif

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;
    int   done_cnt_a;

    param_bank_loader_if #(.DATA_W(16), .ROWS(4), .COLS(16)) bus_a ();
    param_bank_loader_if #(.DATA_W(16), .ROWS(3), .COLS(5))  bus_b ();

    param_bank_loader #(.DATA_W(16), .ROWS(4), .COLS(16)) u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    param_bank_loader #(.DATA_W(16), .ROWS(3), .COLS(5)) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count load_done pulses of the main instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus_a.load_done === 1'b1) done_cnt_a <= done_cnt_a + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_a(input int r, input int c, output logic [15:0] d);
        bus_a.seli = r[1:0];
        bus_a.selj = c[3:0];
        tick();
        d = bus_a.param_out;
    endtask

    task automatic rd_b(input int r, input int c, output logic [15:0] d);
        bus_b.seli = r[1:0];
        bus_b.selj = c[2:0];
        tick();
        d = bus_b.param_out;
    endtask

    initial begin
        logic [15:0] d;
        int          ready_cnt;
        int          base;
        int          cyc;
        int          k;
        bit          got;

        n_checks = 0;
        n_fail   = 0;
        done_cnt_a = 0;
        reset_n  = 1'b0;
        {bus_a.write, bus_a.load_start, bus_a.load_valid, bus_a.load_abort} = 4'b0000;
        {bus_b.write, bus_b.load_start, bus_b.load_valid, bus_b.load_abort} = 4'b0000;
        bus_a.seli = 2'd0; bus_a.selj = 4'd0; bus_a.param_in = 16'h0000;
        bus_b.seli = 2'd0; bus_b.selj = 3'd0; bus_b.param_in = 16'h0000;

        // Reset state
        #1;
        check("rst_busy",  32'(bus_a.busy), 32'd0);
        check("rst_ready", 32'(bus_a.load_ready), 32'd0);
        check("rst_done",  32'(bus_a.load_done), 32'd0);
        check("rst_out",   32'(bus_a.param_out), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single write at (1,3); everything else stays zero
        bus_a.write = 1'b1; bus_a.seli = 2'd1; bus_a.selj = 4'd3; bus_a.param_in = 16'hDEAD;
        tick();
        bus_a.write = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 16; c++) begin
                rd_a(r, c, d);
                check("single_wr", 32'(d), (r == 1 && c == 3) ? 32'h0000DEAD : 32'd0);
            end
        end

        // Continuous stream of 64 words
        base = done_cnt_a;
        bus_a.load_start = 1'b1;
        tick();
        bus_a.load_start = 1'b0;
        bus_a.load_valid = 1'b1;
        ready_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            bus_a.param_in = 16'(i);
            if (bus_a.load_ready) ready_cnt++;
            tick();
        end
        bus_a.load_valid = 1'b0;
        check("stream_ready_cycles", 32'(ready_cnt), 32'd64);
        check("stream_done_hi",      32'(bus_a.load_done), 32'd1);
        check("stream_done_ready",   32'(bus_a.load_ready), 32'd0);
        tick();
        check("stream_done_lo",      32'(bus_a.load_done), 32'd0);
        check("stream_idle",         32'(bus_a.busy), 32'd0);
        check("stream_done_count",   32'(done_cnt_a - base), 32'd1);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 16; c++) begin
                rd_a(r, c, d);
                check("stream_data", 32'(d), 32'(16 * r + c));
            end
        end

        // Clear, then stream with load_valid toggling; idle cycles carry junk
        reset_n = 1'b0;
        #1;
        rd_a(2, 7, d);
        check("reset_clear", 32'(d), 32'd0);
        reset_n = 1'b1;
        tick();
        bus_a.load_start = 1'b1;
        tick();
        bus_a.load_start = 1'b0;
        k = 0; cyc = 0; got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            bus_a.load_valid = (i % 2 == 0);
            bus_a.param_in   = bus_a.load_valid ? 16'(k) : 16'hFFFF;
            tick();
            if (bus_a.load_valid) k++;
            cyc = i + 1;
            if (bus_a.load_done) got = 1'b1;
        end
        bus_a.load_valid = 1'b0;
        check("toggle_done_seen",    32'(got), 32'd1);
        check("toggle_done_latency", 32'(cyc), 32'd127);
        tick();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 16; c++) begin
                rd_a(r, c, d);
                check("toggle_data", 32'(d), 32'(16 * r + c));
            end
        end

        // Write together with load_start, then abort after 10 words
        bus_a.load_start = 1'b1;
        bus_a.write = 1'b1; bus_a.seli = 2'd3; bus_a.selj = 4'd15; bus_a.param_in = 16'h1234;
        tick();
        bus_a.load_start = 1'b0;
        bus_a.seli = 2'd2; bus_a.selj = 4'd5;
        bus_a.load_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus_a.param_in = 16'hA000 + 16'(i);
            tick();
        end
        base = done_cnt_a;
        bus_a.load_abort = 1'b1;
        bus_a.param_in = 16'hBEEF;
        tick();
        check("abort_busy", 32'(bus_a.busy), 32'd0);
        bus_a.write = 1'b0; bus_a.load_abort = 1'b0; bus_a.load_valid = 1'b0;
        tick();
        tick();
        check("abort_no_done", 32'(done_cnt_a - base), 32'd0);
        for (int c = 0; c < 10; c++) begin
            rd_a(0, c, d);
            check("abort_written", 32'(d), 32'h0000A000 + 32'(c));
        end
        rd_a(0, 10, d);
        check("abort_kept",        32'(d), 32'd10);
        rd_a(2, 5, d);
        check("stream_write_ign",  32'(d), 32'd37);
        rd_a(3, 15, d);
        check("write_with_start",  32'(d), 32'h00001234);

        // Asynchronous reset in the middle of a stream
        base = done_cnt_a;
        bus_a.load_start = 1'b1;
        tick();
        bus_a.load_start = 1'b0;
        bus_a.load_valid = 1'b1;
        bus_a.param_in = 16'h5555;
        tick();
        bus_a.param_in = 16'h6666;
        tick();
        bus_a.load_valid = 1'b0;
        bus_a.seli = 2'd0; bus_a.selj = 4'd0;
        check("midrst_busy_before", 32'(bus_a.busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_busy",  32'(bus_a.busy), 32'd0);
        check("midrst_ready", 32'(bus_a.load_ready), 32'd0);
        check("midrst_out",   32'(bus_a.param_out), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("midrst_no_done", 32'(done_cnt_a - base), 32'd0);
        rd_a(0, 1, d);
        check("midrst_clear01", 32'(d), 32'd0);
        rd_a(3, 15, d);
        check("midrst_clear315", 32'(d), 32'd0);

        // 3x5 geometry: 15-word stream, out-of-range writes and reads
        bus_b.load_start = 1'b1;
        tick();
        bus_b.load_start = 1'b0;
        bus_b.load_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            bus_b.param_in = 16'd100 + 16'(i);
            tick();
        end
        bus_b.load_valid = 1'b0;
        check("b_done", 32'(bus_b.load_done), 32'd1);
        tick();
        check("b_idle", 32'(bus_b.busy), 32'd0);
        bus_b.write = 1'b1; bus_b.seli = 2'd3; bus_b.selj = 3'd0; bus_b.param_in = 16'h7777;
        tick();
        bus_b.seli = 2'd0; bus_b.selj = 3'd5; bus_b.param_in = 16'h8888;
        tick();
        bus_b.write = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 5; c++) begin
                rd_b(r, c, d);
                check("b_data", 32'(d), 32'(100 + 5 * r + c));
            end
        end
        rd_b(3, 0, d);
        check("b_row_oor", 32'(d), 32'd0);
        rd_b(0, 5, d);
        check("b_col_oor", 32'(d), 32'd0);
        rd_b(0, 0, d);
        check("b_lat_base", 32'(d), 32'd100);
        bus_b.seli = 2'd2; bus_b.selj = 3'd4;
        #1;
        check("b_lat_immediate", 32'(bus_b.param_out), (RD_LAT == 1) ? 32'd100 : 32'd114);
        tick();
        check("b_lat_next", 32'(bus_b.param_out), 32'd114);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
